// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the MIPS-Lite multi-cycle controller: opcodes, functs,
// state codes, decode class indices and datapath select encodings.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    // one-hot decode class vector bit positions
    localparam int C_RTYPE = 0;
    localparam int C_JR    = 1;
    localparam int C_ORI   = 2;
    localparam int C_LUI   = 3;
    localparam int C_LW    = 4;
    localparam int C_SW    = 5;
    localparam int C_BEQ   = 6;
    localparam int C_J     = 7;
    localparam int C_JAL   = 8;
    localparam int C_ILL   = 9;
    localparam int NCLS    = 10;

    typedef logic [NCLS-1:0] cls_t;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// write strobes, mux selects, op codes and debug state out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCWr;
    logic       IRWr;
    logic       RFWr;
    logic       DMWr;
    logic [1:0] NPCOp;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic       ALUSrc;
    logic [1:0] ExtOp;
    logic [1:0] ALUOp;
    logic [2:0] state;

    modport master (
        input  op, funct, zero,
        output PCWr, IRWr, RFWr, DMWr, NPCOp, RegDst, WDSel,
               ALUSrc, ExtOp, ALUOp, state
    );

    modport slave (
        output op, funct, zero,
        input  PCWr, IRWr, RFWr, DMWr, NPCOp, RegDst, WDSel,
               ALUSrc, ExtOp, ALUOp, state
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to a one-hot class vector.
// Exactly one bit is always set; unknown encodings fall into C_ILL.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) cls[C_RTYPE] = 1'b1;
                else if (funct == FN_JR)                  cls[C_JR]    = 1'b1;
                else                                      cls[C_ILL]   = 1'b1;
            end
            OP_ORI:  cls[C_ORI] = 1'b1;
            OP_LUI:  cls[C_LUI] = 1'b1;
            OP_LW:   cls[C_LW]  = 1'b1;
            OP_SW:   cls[C_SW]  = 1'b1;
            OP_BEQ:  cls[C_BEQ] = 1'b1;
            OP_J:    cls[C_J]   = 1'b1;
            OP_JAL:  cls[C_JAL] = 1'b1;
            default: cls[C_ILL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// MIPS-Lite multi-cycle control unit: FETCH/DCD/EXE/MEM/WB sequencer with
// Moore outputs on state plus the decoded class of the instruction in IR.
//
// state | meaning
// FETCH | IR <= mem[PC], PC <= PC+4
// DCD   | read registers; jumps complete here
// EXE   | ALU operation; beq resolves here
// MEM   | data memory access (lw/sw)
// WB    | register file write
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    state_t state_q;
    cls_t   cls;

    logic       pcwr, irwr, rfwr, dmwr, alusrc;
    logic [1:0] npcop, regdst, wdsel, extop, aluop;

    mc_decode u_decode (
        .op    (bus.op),
        .funct (bus.funct),
        .cls   (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DCD;
                S_DCD: begin
                    if (cls[C_J] | cls[C_JAL] | cls[C_JR] | cls[C_ILL])
                        state_q <= S_FETCH;
                    else
                        state_q <= S_EXE;
                end
                S_EXE: begin
                    if (cls[C_BEQ])              state_q <= S_FETCH;
                    else if (cls[C_LW] | cls[C_SW]) state_q <= S_MEM;
                    else                         state_q <= S_WB;
                end
                S_MEM:   state_q <= cls[C_LW] ? S_WB : S_FETCH;
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs cannot be pre-registered: DCD depends on the IR loaded at the
    // FETCH edge and beq's PCWr follows the ALU zero flag in the same cycle.
    always_comb begin
        pcwr   = 1'b0;
        irwr   = 1'b0;
        rfwr   = 1'b0;
        dmwr   = 1'b0;
        npcop  = NPC_PC4;
        regdst = RD_RT;
        wdsel  = WD_ALU;
        alusrc = 1'b0;
        extop  = EXT_ZERO;
        aluop  = ALU_ADD;
        if (!rst) begin
            // ALU operand/op selects stay valid from EXE until the write completes
            if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
                if (cls[C_RTYPE]) begin
                    aluop = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                end else if (cls[C_ORI]) begin
                    alusrc = 1'b1;
                    extop  = EXT_ZERO;
                    aluop  = ALU_OR;
                end else if (cls[C_LUI]) begin
                    alusrc = 1'b1;
                    extop  = EXT_LUI;
                    aluop  = ALU_OR;
                end else if (cls[C_LW] | cls[C_SW]) begin
                    alusrc = 1'b1;
                    extop  = EXT_SIGN;
                    aluop  = ALU_ADD;
                end else if (cls[C_BEQ]) begin
                    aluop  = ALU_SUB;
                end
            end
            case (state_q)
                S_FETCH: begin
                    pcwr  = 1'b1;
                    irwr  = 1'b1;
                    npcop = NPC_PC4;
                end
                S_DCD: begin
                    if (cls[C_J]) begin
                        pcwr  = 1'b1;
                        npcop = NPC_J;
                    end else if (cls[C_JAL]) begin
                        pcwr   = 1'b1;
                        npcop  = NPC_J;
                        rfwr   = 1'b1;
                        regdst = RD_RA;
                        wdsel  = WD_PC;
                    end else if (cls[C_JR]) begin
                        pcwr  = 1'b1;
                        npcop = NPC_JR;
                    end
                end
                S_EXE: begin
                    if (cls[C_BEQ]) begin
                        npcop = NPC_BR;
                        pcwr  = bus.zero;
                    end
                end
                S_MEM: dmwr = cls[C_SW];
                S_WB: begin
                    if (cls[C_RTYPE]) begin
                        rfwr   = 1'b1;
                        regdst = RD_RD;
                        wdsel  = WD_ALU;
                    end else if (cls[C_ORI] | cls[C_LUI]) begin
                        rfwr   = 1'b1;
                        regdst = RD_RT;
                        wdsel  = WD_ALU;
                    end else if (cls[C_LW]) begin
                        rfwr   = 1'b1;
                        regdst = RD_RT;
                        wdsel  = WD_DM;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWr   = pcwr;
    assign bus.IRWr   = irwr;
    assign bus.RFWr   = rfwr;
    assign bus.DMWr   = dmwr;
    assign bus.NPCOp  = npcop;
    assign bus.RegDst = regdst;
    assign bus.WDSel  = wdsel;
    assign bus.ALUSrc = alusrc;
    assign bus.ExtOp  = extop;
    assign bus.ALUOp  = aluop;
    assign bus.state  = state_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-Lite datapath.
- Sequences each instruction through FETCH/DCD/EXE/MEM/WB.
- Drives the select inputs of the datapath muxes: RegDst (3:1, 5-bit), WDSel (3:1, 32-bit) and ALUSrc (2:1, 32-bit).
- Drives all architectural write strobes and the NPC/ALU/EXT op codes.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26]; must be stable from DCD onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in EXE.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write enable.
- NPCOp  out  2  next-PC source: 00 PC+4, 01 branch, 10 J target, 11 rs (jr).
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- WDSel  out  2  write-data select: 00 ALU, 01 DM, 10 PC (PC+4).
- ALUSrc  out  1  ALU B operand: 0 rt, 1 extended immediate.
- ExtOp  out  2  immediate extend: 00 zero-ext, 01 sign-ext, 10 imm<<16.
- ALUOp  out  2  ALU operation: 00 ADD, 01 SUB, 10 OR.
- state  out  3  current state, for debug and bench.

Behaviour:
- Reset:
  - rst=1 forces state=FETCH immediately.
  - While rst=1, all strobes (PCWr, IRWr, RFWr, DMWr) are forced 0 and all selects/ops are 0.
  - The first fetch occurs on the first rising edge after rst deasserts.
- State encoding: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with all strobes 0.
- Decode classes:
  - RTYPE: op=000000 with funct addu(100001) or subu(100011).
  - JR: op=000000, funct=001000.
  - ORI=001101, LUI=001111, LW=100011, SW=101011, BEQ=000100, J=000010, JAL=000011.
  - Anything else is ILLEGAL.
- Transitions:
  - FETCH -> DCD.
  - DCD: J/JAL/JR/ILLEGAL -> FETCH; all others -> EXE.
  - EXE: BEQ -> FETCH; LW/SW -> MEM; RTYPE/ORI/LUI -> WB.
  - MEM: LW -> WB; SW -> FETCH.
  - WB -> FETCH.
- Cycles per instruction: J/JAL/JR/ILLEGAL 2, BEQ 3, SW 4, RTYPE/ORI/LUI 4, LW 5.
- Outputs (Moore on state plus decoded class; all unlisted outputs are 0):
  - FETCH: PCWr=1, IRWr=1, NPCOp=00.
  - DCD, J: PCWr=1, NPCOp=10.
  - DCD, JAL: PCWr=1, NPCOp=10, RFWr=1, RegDst=10, WDSel=10. PC already holds PC+4, so $31 receives the return address.
  - DCD, JR: PCWr=1, NPCOp=11.
  - DCD, ILLEGAL: no strobes; behaves as a nop.
  - EXE, RTYPE: ALUSrc=0; ALUOp=00 for addu, 01 for subu.
  - EXE, ORI: ALUSrc=1, ExtOp=00, ALUOp=10.
  - EXE, LUI: ALUSrc=1, ExtOp=10, ALUOp=10. Zero-register B operand is not assumed; OR with rs per datapath.
  - EXE, LW/SW: ALUSrc=1, ExtOp=01, ALUOp=00.
  - EXE, BEQ: ALUSrc=0, ALUOp=01, NPCOp=01, PCWr=zero.
  - MEM, SW: DMWr=1. MEM, LW: no strobe.
  - WB, RTYPE: RFWr=1, RegDst=01, WDSel=00.
  - WB, ORI/LUI: RFWr=1, RegDst=00, WDSel=00.
  - WB, LW: RFWr=1, RegDst=00, WDSel=01.
- Selects hold their EXE values through MEM/WB where the datapath needs them (ALUSrc/ExtOp/ALUOp are decoded from class in EXE, MEM and WB).
- At most one of RFWr/DMWr is high in any cycle.
- IRWr is high only in FETCH.
- RegDst=11 and WDSel=11 are never driven.
- Reset mid-instruction aborts without completing any write. The instruction is refetched from the reset PC.

Decomposition:
- Shared package/include holds:
  - opcode and funct constants;
  - state codes;
  - NPCOp/ALUOp/ExtOp/RegDst/WDSel encodings.
- One combinational sub-module, mc_decode (op, funct -> one-hot class vector), instantiated in mc_ctrl.
- The state register and output logic stay in mc_ctrl.

Test Plan:
- Reset: rst=1 pulsed mid-EXE of an addu -> state=0 within the same cycle, all strobes 0 while rst is high, FETCH strobes (PCWr=IRWr=1) on the first cycle after release.
- addu (op=0, funct=0x21) -> states 0,1,2,4,0; WB: RFWr=1, RegDst=01, WDSel=00; EXE ALUOp=00.
- lw (op=0x23) -> states 0,1,2,3,4; EXE ALUSrc=1, ExtOp=01; WB: RFWr=1, RegDst=00, WDSel=01. sw (0x2B) -> DMWr=1 only in MEM, 4 cycles.
- beq (op=0x04) with zero=1 -> EXE PCWr=1, NPCOp=01; with zero=0 -> PCWr=0; back to FETCH after 3 cycles in both cases.
- jal (op=0x03) -> DCD: PCWr=1, NPCOp=10, RFWr=1, RegDst=10, WDSel=10, then FETCH. jr (op=0, funct=0x08) -> DCD: NPCOp=11, RFWr=0.
- Illegal op=0x3F and R-type funct=0x20 -> DCD -> FETCH with no RFWr/DMWr; back-to-back mixed instruction stream checks that at most one of RFWr/DMWr is high in every cycle.
